// File: rtl/ex_stage_pipe_pkg.sv
// Shared opcode encodings, operand-select codes and result flag bundles
// for the two-accumulator execute stage.
package ex_stage_pipe_pkg;

  typedef enum logic [5:0] {
    OP_ADDA  = 6'h01,
    OP_ADDB  = 6'h02,
    OP_ADDCA = 6'h03,
    OP_ADDCB = 6'h04,
    OP_SUBA  = 6'h05,
    OP_SUBCA = 6'h06,
    OP_SUBCB = 6'h07,
    OP_ANDA  = 6'h08,
    OP_ANDB  = 6'h09,
    OP_ANDCA = 6'h0A,
    OP_ANDCB = 6'h0B,
    OP_ORA   = 6'h0C,
    OP_ORB   = 6'h0D,
    OP_ORCA  = 6'h0E,
    OP_ORCB  = 6'h0F,
    OP_ASLA  = 6'h10,
    OP_ASRA  = 6'h11,
    OP_BAEQ  = 6'h12,
    OP_BANE  = 6'h13,
    OP_BAMI  = 6'h14,
    OP_BAPL  = 6'h15,
    OP_BBEQ  = 6'h16,
    OP_BBNE  = 6'h17,
    OP_BBMI  = 6'h18,
    OP_BBPL  = 6'h19
  } opcode_e;

  // x/y operand pairing presented to the ALU
  typedef enum logic [1:0] {
    SRC_AB,
    SRC_AC,
    SRC_BC,
    SRC_B
  } src_e;

  typedef struct packed {
    logic carry;
    logic br_taken;
    logic wb_en;
    logic wb_sel;
    logic illegal;
  } alu_flags_t;

  typedef struct packed {
    logic wb_sel;
    logic wb_en;
    logic zero;
    logic neg;
    logic carry;
    logic br_taken;
    logic illegal;
  } out_flags_t;

  function automatic src_e op_src(
    input logic [5:0] op
  );
    src_e s;
    s = SRC_AB;
    case (op)
      OP_ADDCA, OP_SUBCA,
      OP_ANDCA, OP_ORCA:  s = SRC_AC;
      OP_ADDCB, OP_SUBCB,
      OP_ANDCB, OP_ORCB:  s = SRC_BC;
      OP_BBEQ, OP_BBNE,
      OP_BBMI, OP_BBPL:   s = SRC_B;
      default:            s = SRC_AB;
    endcase
    return s;
  endfunction

  function automatic logic dest_b(
    input logic [5:0] op
  );
    logic d;
    d = 1'b0;
    case (op)
      OP_ADDB, OP_ADDCB,
      OP_SUBCB,
      OP_ANDB, OP_ANDCB,
      OP_ORB,  OP_ORCB:  d = 1'b1;
      default:           d = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ex_stage_pipe_if.sv
// Decode-to-execute-to-writeback handshake bundle.
// Master is the decode/writeback side, slave is the execute stage.
interface ex_stage_pipe_if #(
  parameter int DATA_W = 8
);
  logic              iValid;
  logic              oReady;
  logic [5:0]        iAluInstSel;
  logic [DATA_W-1:0] iAcumA;
  logic [DATA_W-1:0] iAcumB;
  logic [DATA_W-1:0] iConst;
  logic              oValid;
  logic              iReady;
  logic [DATA_W-1:0] oAluData;
  logic              oWbSel;
  logic              oWbEn;
  logic              oZero;
  logic              oNeg;
  logic              oCarry;
  logic              oBrTaken;
  logic              oIllegal;

  modport master (
    output iValid, iAluInstSel,
    output iAcumA, iAcumB, iConst,
    output iReady,
    input  oReady, oValid, oAluData,
    input  oWbSel, oWbEn, oZero, oNeg,
    input  oCarry, oBrTaken, oIllegal
  );

  modport slave (
    input  iValid, iAluInstSel,
    input  iAcumA, iAcumB, iConst,
    input  iReady,
    output oReady, oValid, oAluData,
    output oWbSel, oWbEn, oZero, oNeg,
    output oCarry, oBrTaken, oIllegal
  );
endinterface

// File: rtl/ex_stage_pipe_alu_core.sv
// Combinational ALU and branch evaluator for the execute stage.
// x is the primary operand (minuend, shifted or tested value).
module alu_core
  import ex_stage_pipe_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [5:0]        op,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  output logic [DATA_W-1:0] res,
  output alu_flags_t        flags
);

  logic [DATA_W:0] sum;

  always_comb begin
    res   = '0;
    flags = '0;
    sum   = '0;
    unique case (op)
      OP_ADDA, OP_ADDB,
      OP_ADDCA, OP_ADDCB: begin
        sum         = {1'b0, x} + {1'b0, y};
        res         = sum[DATA_W-1:0];
        flags.carry = sum[DATA_W];
        flags.wb_en = 1'b1;
      end
      OP_SUBA, OP_SUBCA,
      OP_SUBCB: begin
        // top bit of the widened difference is the borrow
        sum         = {1'b0, x} - {1'b0, y};
        res         = sum[DATA_W-1:0];
        flags.carry = ~sum[DATA_W];
        flags.wb_en = 1'b1;
      end
      OP_ANDA, OP_ANDB,
      OP_ANDCA, OP_ANDCB: begin
        res         = x & y;
        flags.wb_en = 1'b1;
      end
      OP_ORA, OP_ORB,
      OP_ORCA, OP_ORCB: begin
        res         = x | y;
        flags.wb_en = 1'b1;
      end
      OP_ASLA: begin
        res         = {x[DATA_W-2:0], 1'b0};
        flags.carry = x[DATA_W-1];
        flags.wb_en = 1'b1;
      end
      OP_ASRA: begin
        res         = {x[DATA_W-1], x[DATA_W-1:1]};
        flags.carry = x[0];
        flags.wb_en = 1'b1;
      end
      OP_BAEQ, OP_BBEQ: begin
        res            = x;
        flags.br_taken = (x == '0);
      end
      OP_BANE, OP_BBNE: begin
        res            = x;
        flags.br_taken = (x != '0);
      end
      OP_BAMI, OP_BBMI: begin
        res            = x;
        flags.br_taken = x[DATA_W-1];
      end
      OP_BAPL, OP_BBPL: begin
        res            = x;
        flags.br_taken = ~x[DATA_W-1];
      end
      default: begin
        flags.illegal = 1'b1;
      end
    endcase
    flags.wb_sel = dest_b(op);
  end

endmodule

// File: rtl/ex_stage_pipe.sv
// Registered execute stage: operand mux, ALU and a single output
// register under a valid/ready handshake with zero-bubble refill.
module ex_stage_pipe
  import ex_stage_pipe_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input logic          Clock,
  input logic          Reset,
  ex_stage_pipe_if.slave bus
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  out_flags_t        flags_q, flags_d;

  logic              ready;
  logic              accept;
  logic [DATA_W-1:0] op_x, op_y;
  logic [DATA_W-1:0] alu_res;
  alu_flags_t        alu_flags;

  assign ready  = !valid_q || bus.iReady;
  assign accept = bus.iValid && ready;

  always_comb begin
    op_x = bus.iAcumA;
    op_y = bus.iAcumB;
    unique case (op_src(bus.iAluInstSel))
      SRC_AC: op_y = bus.iConst;
      SRC_BC: begin
        op_x = bus.iAcumB;
        op_y = bus.iConst;
      end
      SRC_B:  op_x = bus.iAcumB;
      default: begin
        op_x = bus.iAcumA;
        op_y = bus.iAcumB;
      end
    endcase
  end

  alu_core #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op    (bus.iAluInstSel),
    .x     (op_x),
    .y     (op_y),
    .res   (alu_res),
    .flags (alu_flags)
  );

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    flags_d = flags_q;
    if (accept) begin
      valid_d          = 1'b1;
      data_d           = alu_res;
      flags_d.wb_sel   = alu_flags.wb_sel;
      flags_d.wb_en    = alu_flags.wb_en;
      // illegal results carry no flags even though the data is zero
      flags_d.zero     = (alu_res == '0) && !alu_flags.illegal;
      flags_d.neg      = alu_res[DATA_W-1];
      flags_d.carry    = alu_flags.carry;
      flags_d.br_taken = alu_flags.br_taken;
      flags_d.illegal  = alu_flags.illegal;
    end else if (bus.iReady) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      flags_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      flags_q <= flags_d;
    end
  end

  assign bus.oReady   = ready;
  assign bus.oValid   = valid_q;
  assign bus.oAluData = data_q;
  assign bus.oWbSel   = flags_q.wb_sel;
  assign bus.oWbEn    = flags_q.wb_en;
  assign bus.oZero    = flags_q.zero;
  assign bus.oNeg     = flags_q.neg;
  assign bus.oCarry   = flags_q.carry;
  assign bus.oBrTaken = flags_q.br_taken;
  assign bus.oIllegal = flags_q.illegal;

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Scoreboard bench for ex_stage_pipe at DATA_W=8 and DATA_W=16.
// Expected results are queued on accept and popped as they drain.
module tb_ex_stage_pipe;

  typedef struct packed {
    logic [15:0] d;
    logic sel;
    logic en;
    logic z;
    logic n;
    logic c;
    logic br;
    logic ill;
  } exp_t;

  logic clk = 1'b0;
  logic Reset = 1'b1;
  int errors = 0;
  int checks = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  ex_stage_pipe_if #(.DATA_W(8))  bus8 ();
  ex_stage_pipe_if #(.DATA_W(16)) bus16 ();

  ex_stage_pipe #(.DATA_W(8)) dut8 (
    .Clock (clk),
    .Reset (Reset),
    .bus   (bus8.slave)
  );

  ex_stage_pipe #(.DATA_W(16)) dut16 (
    .Clock (clk),
    .Reset (Reset),
    .bus   (bus16.slave)
  );

  function automatic exp_t mk(
    input logic [15:0] d,
    input logic sel, en, z, n, c, br, ill
  );
    exp_t e;
    e.d = d; e.sel = sel; e.en = en;
    e.z = z; e.n = n; e.c = c;
    e.br = br; e.ill = ill;
    return e;
  endfunction

  function automatic exp_t obs8();
    return mk(16'(bus8.oAluData), bus8.oWbSel, bus8.oWbEn,
              bus8.oZero, bus8.oNeg, bus8.oCarry,
              bus8.oBrTaken, bus8.oIllegal);
  endfunction

  function automatic exp_t obs16();
    return mk(bus16.oAluData, bus16.oWbSel, bus16.oWbEn,
              bus16.oZero, bus16.oNeg, bus16.oCarry,
              bus16.oBrTaken, bus16.oIllegal);
  endfunction

  // Independent 8-bit reference built on integer arithmetic
  function automatic exp_t ref8(
    input logic [5:0] op,
    input logic [7:0] a, b, c
  );
    int x, y, r;
    exp_t e;
    e = '0;
    x = int'(a);
    y = int'(b);
    r = 0;
    if (op inside {6'h03, 6'h06, 6'h0A, 6'h0E}) y = int'(c);
    if (op inside {6'h04, 6'h07, 6'h0B, 6'h0F}) begin
      x = int'(b);
      y = int'(c);
    end
    if (op inside {[6'h16:6'h19]}) x = int'(b);
    e.sel = op inside {6'h02, 6'h04, 6'h07, 6'h09,
                       6'h0B, 6'h0D, 6'h0F};
    case (op)
      6'h01, 6'h02, 6'h03, 6'h04: begin
        r = x + y; e.c = (r > 255); e.en = 1'b1;
      end
      6'h05, 6'h06, 6'h07: begin
        r = x - y; e.c = (x >= y); e.en = 1'b1;
      end
      6'h08, 6'h09, 6'h0A, 6'h0B: begin
        r = x & y; e.en = 1'b1;
      end
      6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        r = x | y; e.en = 1'b1;
      end
      6'h10: begin
        r = x * 2; e.c = (x >= 128); e.en = 1'b1;
      end
      6'h11: begin
        r = (x / 2) + (x & 128); e.c = ((x % 2) != 0); e.en = 1'b1;
      end
      6'h12, 6'h16: begin r = x; e.br = (x == 0);   end
      6'h13, 6'h17: begin r = x; e.br = (x != 0);   end
      6'h14, 6'h18: begin r = x; e.br = (x >= 128); end
      6'h15, 6'h19: begin r = x; e.br = (x < 128);  end
      default: e.ill = 1'b1;
    endcase
    r = r & 255;
    e.d = 16'(r);
    e.z = (r == 0) && !e.ill;
    e.n = (r >= 128);
    return e;
  endfunction

  task automatic drv8(
    input logic [5:0] op,
    input logic [7:0] a, b, c
  );
    bus8.iValid = 1'b1;
    bus8.iAluInstSel = op;
    bus8.iAcumA = a;
    bus8.iAcumB = b;
    bus8.iConst = c;
  endtask

  task automatic step8(
    input logic [5:0] op,
    input logic [7:0] a, b, c
  );
    drv8(op, a, b, c);
    @(posedge clk);
    #1;
    bus8.iValid = 1'b0;
  endtask

  task automatic test_reset();
    exp_t o;
    Reset = 1'b1;
    #1;
    o = obs8();
    checks++;
    if (o !== '0 || bus8.oValid !== 1'b0 || bus8.oReady !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got %h v=%b r=%b want 0 v=0 r=1",
               o, bus8.oValid, bus8.oReady);
    end
    Reset = 1'b0;
    bus8.iReady = 1'b0;
    step8(6'h01, 8'h12, 8'h34, 8'h00);
    checks++;
    if (bus8.oValid !== 1'b1 || bus8.oReady !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall_setup: got v=%b r=%b want v=1 r=0",
               bus8.oValid, bus8.oReady);
    end
    Reset = 1'b1;
    #1;
    o = obs8();
    checks++;
    if (o !== '0 || bus8.oValid !== 1'b0 || bus8.oReady !== 1'b1) begin
      errors++;
      $display("FAIL reset_midstall: got %h v=%b r=%b want 0 v=0 r=1",
               o, bus8.oValid, bus8.oReady);
    end
    Reset = 1'b0;
    bus8.iReady = 1'b1;
  endtask

  task automatic test_add();
    exp_t e;
    sbq.push_back(mk(16'h0010, 0, 1, 0, 0, 1, 0, 0));
    step8(6'h01, 8'hF0, 8'h20, 8'h00);
    e = sbq.pop_front();
    checks++;
    if (obs8() !== e || bus8.oValid !== 1'b1) begin
      errors++;
      $display("FAIL adda: got %h v=%b want %h v=1", obs8(), bus8.oValid, e);
    end
  endtask

  task automatic test_sub();
    exp_t e;
    sbq.push_back(mk(16'h0000, 1, 1, 1, 0, 1, 0, 0));
    step8(6'h07, 8'h11, 8'h05, 8'h05);
    e = sbq.pop_front();
    checks++;
    if (obs8() !== e) begin
      errors++;
      $display("FAIL subcb: got %h want %h", obs8(), e);
    end
    sbq.push_back(mk(16'h00FF, 0, 1, 0, 1, 0, 0, 0));
    step8(6'h06, 8'h03, 8'h77, 8'h04);
    e = sbq.pop_front();
    checks++;
    if (obs8() !== e) begin
      errors++;
      $display("FAIL subca: got %h want %h", obs8(), e);
    end
  endtask

  task automatic test_shift();
    exp_t e;
    sbq.push_back(mk(16'h00C0, 0, 1, 0, 1, 1, 0, 0));
    step8(6'h11, 8'h81, 8'h00, 8'h00);
    e = sbq.pop_front();
    checks++;
    if (obs8() !== e) begin
      errors++;
      $display("FAIL asra: got %h want %h", obs8(), e);
    end
    sbq.push_back(mk(16'h0002, 0, 1, 0, 0, 1, 0, 0));
    step8(6'h10, 8'h81, 8'h00, 8'h00);
    e = sbq.pop_front();
    checks++;
    if (obs8() !== e) begin
      errors++;
      $display("FAIL asla: got %h want %h", obs8(), e);
    end
  endtask

  task automatic test_branch_illegal();
    exp_t e;
    sbq.push_back(mk(16'h0080, 0, 0, 0, 1, 0, 1, 0));
    step8(6'h18, 8'h00, 8'h80, 8'h00);
    e = sbq.pop_front();
    checks++;
    if (obs8() !== e) begin
      errors++;
      $display("FAIL bbmi: got %h want %h", obs8(), e);
    end
    sbq.push_back(mk(16'h0001, 0, 0, 0, 0, 0, 0, 0));
    step8(6'h12, 8'h01, 8'h00, 8'h00);
    e = sbq.pop_front();
    checks++;
    if (obs8() !== e) begin
      errors++;
      $display("FAIL baeq: got %h want %h", obs8(), e);
    end
    sbq.push_back(mk(16'h0000, 0, 0, 0, 0, 0, 0, 1));
    step8(6'h3F, 8'hA5, 8'h5A, 8'hFF);
    e = sbq.pop_front();
    checks++;
    if (obs8() !== e) begin
      errors++;
      $display("FAIL illegal: got %h want %h", obs8(), e);
    end
  endtask

  task automatic test_width16();
    exp_t e;
    bus16.iReady = 1'b1;
    bus16.iValid = 1'b1;
    bus16.iAluInstSel = 6'h01;
    bus16.iAcumA = 16'hFFFF;
    bus16.iAcumB = 16'h0001;
    bus16.iConst = 16'h0000;
    sbq.push_back(mk(16'h0000, 0, 1, 1, 0, 1, 0, 0));
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    checks++;
    if (obs16() !== e || bus16.oValid !== 1'b1) begin
      errors++;
      $display("FAIL adda16: got %h v=%b want %h", obs16(), bus16.oValid, e);
    end
    bus16.iAluInstSel = 6'h11;
    bus16.iAcumA = 16'h8001;
    sbq.push_back(mk(16'hC000, 0, 1, 0, 1, 1, 0, 0));
    @(posedge clk);
    #1;
    bus16.iValid = 1'b0;
    e = sbq.pop_front();
    checks++;
    if (obs16() !== e) begin
      errors++;
      $display("FAIL asra16: got %h want %h", obs16(), e);
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 24;
    logic rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int issued, cyc, v;
    logic mv, mr, acc, prev_stall;
    logic [5:0] op;
    logic [7:0] a, b, c;
    exp_t e, prev;
    bus8.iReady = 1'b1;
    bus8.iValid = 1'b0;
    @(posedge clk);
    #1;
    sbq.delete();
    issued = 0;
    cyc = 0;
    mv = 1'b0;
    prev_stall = 1'b0;
    prev = '0;
    while ((issued < N || mv) && cyc < 400) begin
      bus8.iReady = rdy_pat[cyc % 4];
      v = int'($urandom_range(0, 26));
      op = (v == 26) ? 6'h3F : 6'(v);
      a = 8'($urandom);
      b = 8'($urandom);
      c = 8'($urandom);
      if (issued < N) drv8(op, a, b, c);
      else bus8.iValid = 1'b0;
      #1;
      mr = !mv || bus8.iReady;
      checks++;
      if (bus8.oReady !== mr || bus8.oValid !== mv) begin
        errors++;
        $display("FAIL b2b_ready: got r=%b v=%b want r=%b v=%b",
                 bus8.oReady, bus8.oValid, mr, mv);
      end
      if (prev_stall) begin
        checks++;
        if (obs8() !== prev) begin
          errors++;
          $display("FAIL b2b_stable: got %h want %h", obs8(), prev);
        end
      end
      if (mv && bus8.iReady) begin
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL b2b_underflow: got extra result %h want none", obs8());
        end else begin
          e = sbq.pop_front();
          checks++;
          if (obs8() !== e) begin
            errors++;
            $display("FAIL b2b_data: got %h want %h", obs8(), e);
          end
        end
      end
      prev_stall = mv && !bus8.iReady;
      prev = obs8();
      acc = bus8.iValid && mr;
      if (acc) begin
        sbq.push_back(ref8(op, a, b, c));
        issued++;
      end
      mv = acc ? 1'b1 : (bus8.iReady ? 1'b0 : mv);
      @(posedge clk);
      #1;
      cyc++;
    end
    bus8.iValid = 1'b0;
    bus8.iReady = 1'b1;
    checks++;
    if (sbq.size() != 0 || issued != N) begin
      errors++;
      $display("FAIL b2b_count: got issued=%0d left=%0d want issued=%0d left=0",
               issued, sbq.size(), N);
    end
  endtask

  initial begin
    bus8.iValid = 1'b0;
    bus8.iReady = 1'b1;
    bus8.iAluInstSel = '0;
    bus8.iAcumA = '0;
    bus8.iAcumB = '0;
    bus8.iConst = '0;
    bus16.iValid = 1'b0;
    bus16.iReady = 1'b1;
    bus16.iAluInstSel = '0;
    bus16.iAcumA = '0;
    bus16.iAcumB = '0;
    bus16.iConst = '0;
    test_reset();
    test_add();
    test_sub();
    test_shift();
    test_branch_illegal();
    test_width16();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
